// File: rtl/mcseq_pkg.sv
// Shared sequencer definitions: opcode encoding and the stack command bundle
// used between the next-address logic and the LIFO.
package mcseq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SEQ_CONT = 3'd0,
        SEQ_JZ   = 3'd1,
        SEQ_CJP  = 3'd2,
        SEQ_CJS  = 3'd3,
        SEQ_CRTN = 3'd4,
        SEQ_PUSH = 3'd5,
        SEQ_RFCT = 3'd6,
        SEQ_JMAP = 3'd7
    } seq_op_e;

    typedef struct packed {
        logic push;
        logic pop;
        logic clear;
    } stk_cmd_t;

    localparam stk_cmd_t STK_IDLE = '{push: 1'b0, pop: 1'b0, clear: 1'b0};

endpackage

// File: rtl/mcseq_if.sv
// ROM-side bus of the microprogram sequencer together with its status and trace
// outputs; master is the sequencer, slave is the ROM/decode environment.
interface mcseq_if #(
    parameter int AW = 10
);
    import mcseq_pkg::*;

    logic            stall;
    logic [OP_W-1:0] op;
    logic            cond;
    logic [AW-1:0]   din;
    logic [AW-1:0]   map;
    logic [AW-1:0]   rom_addr;
    logic            rom_ena;
    logic [AW-1:0]   upc;
    logic            cnt_zero;
    logic            sfull;
    logic            sempty;
    logic            serr;

    modport master (
        input  stall, op, cond, din, map,
        output rom_addr, rom_ena, upc, cnt_zero, sfull, sempty, serr
    );

    modport slave (
        output stall, op, cond, din, map,
        input  rom_addr, rom_ena, upc, cnt_zero, sfull, sempty, serr
    );

endinterface

// File: rtl/mcseq_stack.sv
// SDEPTH x AW subroutine LIFO: a push when full overwrites TOS, a pop when empty
// reads 0; both set a sticky error that only reset clears. Clear wins over push/pop.
module mcseq_stack
    import mcseq_pkg::*;
#(
    parameter int AW     = 10,
    parameter int SDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  stk_cmd_t      cmd_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] tos_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          err_o
);

    localparam int IW = $clog2(SDEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] SP_FULL = PW'(SDEPTH);

    logic [AW-1:0] mem_q [SDEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic          err_q, err_d;
    logic [IW-1:0] top_idx, wr_idx;
    logic          we;

    assign full_o  = (sp_q == SP_FULL);
    assign empty_o = (sp_q == '0);
    assign err_o   = err_q;
    assign top_idx = IW'(sp_q - PW'(1));
    assign tos_o   = empty_o ? '0 : mem_q[top_idx];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sp_d   = sp_q;
        err_d  = err_q;
        we     = 1'b0;
        wr_idx = sp_q[IW-1:0];
        if (cmd_i.clear) begin
            sp_d = '0;
        end else if (cmd_i.push) begin
            we = 1'b1;
            if (full_o) begin
                wr_idx = top_idx;
                err_d  = 1'b1;
            end else begin
                sp_d = sp_q + PW'(1);
            end
        end else if (cmd_i.pop) begin
            if (empty_o) begin
                err_d = 1'b1;
            end else begin
                sp_d = sp_q - PW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // NOTE: the storage array has no reset; sp=0 already makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/mcseq.sv
// Am2910-style microprogram sequencer: combinational next-address mux feeding the
// microcode ROM, uPC incrementer, loop counter and subroutine LIFO.
module mcseq
    import mcseq_pkg::*;
#(
    parameter int          AW      = 10,
    parameter int          SDEPTH  = 4,
    parameter int unsigned RST_VEC = 0
) (
    input logic     clk,
    input logic     reset,
    mcseq_if.master bus
);

    localparam logic [AW-1:0] RST_ADDR = AW'(RST_VEC);
    localparam logic [AW-1:0] RST_UPC  = RST_ADDR + AW'(1);

    seq_op_e       op;
    logic [AW-1:0] upc_q, upc_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] tos;
    logic          adv;
    stk_cmd_t      cmd, stk_cmd;
    logic          sfull, sempty, serr;

    assign op  = seq_op_e'(bus.op);
    assign adv = !bus.stall;

    always_comb begin
        next_addr = upc_q;
        cnt_d     = cnt_q;
        cmd       = STK_IDLE;
        case (op)
            SEQ_JZ: begin
                next_addr = '0;
                cmd.clear = 1'b1;
            end
            SEQ_CJP: begin
                if (bus.cond) next_addr = bus.din;
            end
            SEQ_CJS: begin
                if (bus.cond) begin
                    next_addr = bus.din;
                    cmd.push  = 1'b1;
                end
            end
            SEQ_CRTN: begin
                if (bus.cond) begin
                    next_addr = tos;
                    cmd.pop   = 1'b1;
                end
            end
            SEQ_PUSH: begin
                cmd.push = 1'b1;
                if (bus.cond) cnt_d = bus.din;
            end
            SEQ_RFCT: begin
                // Loop back while the counter is live; the exit discards the loop address.
                if (cnt_q != '0) begin
                    next_addr = tos;
                    cnt_d     = cnt_q - AW'(1);
                end else begin
                    cmd.pop = 1'b1;
                end
            end
            SEQ_JMAP: next_addr = bus.map;
            default:  ;
        endcase
        if (reset) next_addr = RST_ADDR;
    end

    assign stk_cmd = adv ? cmd : STK_IDLE;
    assign upc_d   = next_addr + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q <= RST_UPC;
            cnt_q <= '0;
        end else if (adv) begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
        end
    end

    mcseq_stack #(
        .AW     (AW),
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .cmd_i   (stk_cmd),
        .data_i  (upc_q),
        .tos_o   (tos),
        .full_o  (sfull),
        .empty_o (sempty),
        .err_o   (serr)
    );

    // Reset keeps the ROM enabled so the reset vector is fetched even under stall.
    assign bus.rom_addr = next_addr;
    assign bus.rom_ena  = reset | ~bus.stall;
    assign bus.upc      = upc_q;
    assign bus.cnt_zero = (cnt_q == '0);
    assign bus.sfull    = sfull;
    assign bus.sempty   = sempty;
    assign bus.serr     = serr;

endmodule
